// File: rtl/logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit
//  Description : Registered bitwise logic slice of the 32-bit ALU. Applies
//                AND / OR / XOR / NOR to operands A and B (chosen by sel) and
//                registers the result together with zero and parity flags.
//                Latency is one cycle; a new operation is accepted every cycle.
//  Ports       : clk     - system clock, rising-edge active
//                rst_n   - asynchronous active-low reset
//                A, B    - WIDTH-bit operands
//                sel     - 2'b00 AND, 2'b01 OR, 2'b10 XOR, 2'b11 NOR
//                R       - registered WIDTH-bit result
//                zero    - registered flag, 1 when R is all zeros
//                parity  - registered flag, XOR-reduction of R
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] R,
  output logic             zero,
  output logic             parity
);

  localparam logic [1:0] C_SEL_AND = 2'b00;
  localparam logic [1:0] C_SEL_OR  = 2'b01;
  localparam logic [1:0] C_SEL_XOR = 2'b10;
  localparam logic [1:0] C_SEL_NOR = 2'b11;

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_d;
  logic             zero_q;
  logic             parity_d;
  logic             parity_q;

  // Next result and flags are all derived from the same combinational value,
  // so the registered flags always describe the registered result.
  always_comb begin
    result_d = '0;
    case (sel)
      C_SEL_AND: result_d = A & B;
      C_SEL_OR:  result_d = A | B;
      C_SEL_XOR: result_d = A ^ B;
      C_SEL_NOR: result_d = ~(A | B);
      default:   result_d = '0;
    endcase
    zero_d   = ~(|result_d);
    parity_d = ^result_d;
  end

  // Reset state is a consistent "all zeros" result: zero=1, parity=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  assign R      = result_q;
  assign zero   = zero_q;
  assign parity = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit
//  Description : Directed self-checking bench for logic_unit. Inputs change
//                1 ns after a rising edge; outputs are sampled 1 ns after the
//                following rising edge (or mid-cycle for async/latency cases).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  sel;
  logic [31:0] R;
  logic        zero;
  logic        parity;

  int checks = 0;
  int errors = 0;

  logic_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .sel    (sel),
    .R      (R),
    .zero   (zero),
    .parity (parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] er,
                         input logic ez, input logic ep);
    chk({tag, ".R"}, R, er);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    chk({tag, ".parity"}, {31'd0, parity}, {31'd0, ep});
  endtask

  // Wait for the edge that captures the current inputs, then settle 1 ns.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    A     = 32'hFFFF_FFFF;
    B     = 32'hFFFF_FFFF;
    sel   = 2'b00;

    // Reset held across several edges
    tick; tick;
    chk_all("reset_hold", 32'h0000_0000, 1'b1, 1'b0);

    // Release between edges, first capture on the next rising edge
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk_all("ones_and", 32'hFFFF_FFFF, 1'b0, 1'b0);

    // All-ones operands, stepping every operation
    sel = 2'b01; tick; chk_all("ones_or",  32'hFFFF_FFFF, 1'b0, 1'b0);
    sel = 2'b10; tick; chk_all("ones_xor", 32'h0000_0000, 1'b1, 1'b0);
    sel = 2'b11; tick; chk_all("ones_nor", 32'h0000_0000, 1'b1, 1'b0);

    // Mixed pattern 1
    A = 32'h0FFF_FFAB; B = 32'hABCF_FFAB;
    sel = 2'b00; tick; chk_all("p1_and", 32'h0BCF_FFAB, 1'b0, 1'b0);
    sel = 2'b01; tick; chk_all("p1_or",  32'hAFFF_FFAB, 1'b0, 1'b1);
    sel = 2'b10; tick; chk_all("p1_xor", 32'hA430_0000, 1'b0, 1'b1);
    sel = 2'b11; tick; chk_all("p1_nor", 32'h5000_0054, 1'b0, 1'b1);

    // Mixed pattern 2
    A = 32'h0F3F_FFAB; B = 32'hA5CF_FFAB;
    sel = 2'b00; tick; chk_all("p2_and", 32'h050F_FFAB, 1'b0, 1'b1);
    sel = 2'b01; tick; chk_all("p2_or",  32'hAFFF_FFAB, 1'b0, 1'b1);
    sel = 2'b10; tick; chk_all("p2_xor", 32'hAAF0_0000, 1'b0, 1'b0);
    sel = 2'b11; tick; chk_all("p2_nor", 32'h5000_0054, 1'b0, 1'b1);

    // Latency: sel change mid-cycle must not affect R before the next edge
    A = 32'h0000_0000; B = 32'h0000_0001; sel = 2'b00;
    tick;
    chk_all("lat_and", 32'h0000_0000, 1'b1, 1'b0);
    #2 sel = 2'b01;
    #1 chk_all("lat_mid", 32'h0000_0000, 1'b1, 1'b0);
    tick;
    chk_all("lat_or", 32'h0000_0001, 1'b0, 1'b1);

    // Async reset while streaming XOR results
    A = 32'h0FFF_FFAB; B = 32'hABCF_FFAB; sel = 2'b10;
    tick;
    chk_all("stream_xor", 32'hA430_0000, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 32'h0000_0000, 1'b1, 1'b0);
    tick;
    chk_all("rst_over_edge", 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk_all("resume_xor", 32'hA430_0000, 1'b0, 1'b1);
    sel = 2'b11; tick; chk_all("resume_nor", 32'h5000_0054, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
